ln_float16: RTL

- Iterative half-precision natural-logarithm unit: ln(x) = E·ln2 + ln(m), with ln(m) evaluated as a Horner-form Taylor series in t = m − 1.
- Inverse companion of the float16 exponential in the transformer math library; it will feed log-softmax and loss paths.
- Holds one FLOAT16_MUL and one FLOAT16_ADD and time-multiplexes them under an FSM.
- Valid/ready on both sides; one operation in flight at a time.

---
 rtl/ln_float16_pkg.sv | 29 ++
 rtl/float16_add.sv | 54 +++++
 rtl/float16_from_int6.sv | 18 +
 rtl/float16_mul.sv | 41 ++++
 rtl/ln_float16.sv | 100 ++++++++++
 5 files changed

// File: rtl/ln_float16_pkg.sv
// Shared types and constants for the float16 natural-log unit.
package ln_float16_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_H_MUL, S_H_ADD, S_T_MUL, S_E_MUL, S_SUM, S_DONE
  } state_t;

  localparam logic [15:0] LN2     = 16'h398C;
  localparam logic [15:0] NEG_ONE = 16'hBC00;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] NEG_INF = 16'hFC00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  // Taylor coefficients of ln(1+t): (-1)^(k+1)/k in binary16
  function automatic logic [15:0] coef(input logic [3:0] k);
    case (k)
      4'd1:    coef = 16'h3C00;
      4'd2:    coef = 16'hB800;
      4'd3:    coef = 16'h3555;
      4'd4:    coef = 16'hB400;
      4'd5:    coef = 16'h3266;
      4'd6:    coef = 16'hB155;
      4'd7:    coef = 16'h3092;
      4'd8:    coef = 16'hB000;
      default: coef = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/float16_add.sv
// binary16 adder, round-to-nearest-even, subnormals flushed to zero.
module float16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic [15:0]       big, sml;
  logic              sa, sb, sub;
  logic [4:0]        ea, eb, d;
  logic [10:0]       ma, mb;
  logic [26:0]       wide;
  logic [13:0]       xa, xb, nrm;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [11:0]       rnd;
  logic [9:0]        frac;
  logic signed [6:0] er;

  always_comb begin
    if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
    else                    begin big = b; sml = a; end
    sa  = big[15];  sb = sml[15];  sub = sa ^ sb;
    ea  = big[14:10]; eb = sml[14:10];
    ma  = (ea == 5'd0) ? 11'd0 : {1'b1, big[9:0]};
    mb  = (eb == 5'd0) ? 11'd0 : {1'b1, sml[9:0]};
    d   = ea - eb;
    // align: 11 mantissa bits + guard + round, everything lower ORed into sticky
    wide = {mb, 16'b0} >> d;
    xa  = {ma, 3'b0};
    xb  = {wide[26:14], |wide[13:0]};
    sum = sub ? ({1'b0, xa} - {1'b0, xb}) : ({1'b0, xa} + {1'b0, xb});
    er  = $signed({2'b0, ea});
    lz  = 4'd0;
    for (int i = 0; i < 14; i++) if (sum[i]) lz = 4'(13 - i);
    if (sum[14]) begin
      nrm = {sum[14:2], sum[1] | sum[0]};
      er  = er + 7'sd1;
    end else begin
      nrm = sum[13:0] << lz;
      er  = er - $signed({3'b0, lz});
    end
    rnd = {1'b0, nrm[13:3]} + 12'(nrm[2] & (nrm[1] | nrm[0] | nrm[3]));
    if (rnd[11]) er = er + 7'sd1;
    frac = rnd[11] ? rnd[10:1] : rnd[9:0];
    y = {sa, er[4:0], frac};
    if (sum == 15'd0)        y = {sa & sb, 15'b0};
    else if (er <= 7'sd0)    y = {sa, 15'b0};
    else if (er >= 7'sd31)   y = {sa, 5'h1F, 10'b0};
    if (ea == 5'h1F) begin
      if (big[9:0] != 10'd0 || (eb == 5'h1F && sub)) y = 16'h7E00;
      else                                           y = big;
    end
  end
endmodule

// File: rtl/float16_from_int6.sv
// Exact conversion of a 6-bit two's-complement integer to binary16.
module float16_from_int6 (
  input  logic [5:0]  v,
  output logic [15:0] y
);
  logic [5:0] mag;
  logic [2:0] p;
  logic [9:0] frac;

  always_comb begin
    mag = v[5] ? 6'(~v + 6'd1) : v;
    p = 3'd0;
    for (int i = 0; i < 6; i++) if (mag[i]) p = 3'(i);
    // leading one lands on bit 10 and drops out as the hidden bit
    frac = 10'({4'b0, mag} << (4'd10 - {1'b0, p}));
    y = (mag == 6'd0) ? 16'h0000 : {v[5], 5'd15 + {2'b0, p}, frac};
  end
endmodule

// File: rtl/float16_mul.sv
// binary16 multiplier, round-to-nearest-even, subnormals flushed to zero.
module float16_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic              s, g, st;
  logic [4:0]        ea, eb;
  logic [21:0]       p;
  logic [10:0]       m;
  logic [11:0]       rnd;
  logic [9:0]        frac;
  logic signed [7:0] er;

  always_comb begin
    s  = a[15] ^ b[15];
    ea = a[14:10];
    eb = b[14:10];
    p  = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    er = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 8'sd15;
    if (p[21]) begin
      m = p[21:11]; g = p[10]; st = |p[9:0]; er = er + 8'sd1;
    end else begin
      m = p[20:10]; g = p[9];  st = |p[8:0];
    end
    rnd = {1'b0, m} + 12'(g & (st | m[0]));
    if (rnd[11]) er = er + 8'sd1;
    frac = rnd[11] ? rnd[10:1] : rnd[9:0];
    y = {s, er[4:0], frac};
    if (er <= 8'sd0)       y = {s, 15'b0};
    else if (er >= 8'sd31) y = {s, 5'h1F, 10'b0};
    if (ea == 5'd0 || eb == 5'd0) y = {s, 15'b0};
    if (ea == 5'h1F || eb == 5'h1F) begin
      if ((ea == 5'h1F && a[9:0] != 10'd0) || (eb == 5'h1F && b[9:0] != 10'd0) ||
          ea == 5'd0 || eb == 5'd0)
        y = 16'h7E00;
      else
        y = {s, 5'h1F, 10'b0};
    end
  end
endmodule

// File: rtl/ln_float16.sv
// Iterative binary16 ln(x) = E*ln2 + ln(m), ln(m) by Horner Taylor series in t = m-1,
// sharing one multiplier and one adder under an FSM.
module ln_float16
  import ln_float16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_TERMS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] ln_out
);
  state_t      state, nxt;
  logic [15:0] x, t, e_f, acc, eln;
  logic [3:0]  k;
  logic [15:0] mul_a, mul_b, mul_y, add_a, add_b, add_y;
  logic [15:0] m_f, e_f16, spec_val;
  logic [5:0]  e_int;
  logic        halve, special;

  float16_mul u_mul (.a(mul_a), .b(mul_b), .y(mul_y));
  float16_add u_add (.a(add_a), .b(add_b), .y(add_y));
  float16_from_int6 u_cvt (.v(e_int), .y(e_f16));

  // operand decode, only meaningful in PRE
  always_comb begin
    halve    = x[9];
    m_f      = {1'b0, halve ? 5'd14 : 5'd15, x[9:0]};
    e_int    = {1'b0, x[14:10]} - 6'd15 + {5'b0, halve};
    special  = 1'b1;
    spec_val = NEG_INF;
    if (x[14:10] == 5'd0)                           spec_val = NEG_INF;
    else if (x[15] || (x[14:10] == 5'h1F && x[9:0] != 10'd0)) spec_val = QNAN;
    else if (x[14:10] == 5'h1F)                     spec_val = POS_INF;
    else                                            special  = 1'b0;
  end

  always_comb begin
    mul_a = t;
    mul_b = acc;
    if (state == S_E_MUL) begin mul_a = e_f; mul_b = LN2; end
    add_a = acc;
    add_b = coef(k);
    case (state)
      S_PRE: begin add_a = m_f; add_b = NEG_ONE; end
      S_SUM: add_b = eln;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (in_vld) nxt = S_PRE;
      S_PRE:   nxt = special ? S_DONE : S_H_MUL;
      S_H_MUL: nxt = S_H_ADD;
      S_H_ADD: nxt = (k == 4'd1) ? S_T_MUL : S_H_MUL;
      S_T_MUL: nxt = S_E_MUL;
      S_E_MUL: nxt = S_SUM;
      S_SUM:   nxt = S_DONE;
      S_DONE:  if (out_rdy) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign in_rdy  = (state == S_IDLE);
  assign out_vld = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0; t <= '0; e_f <= '0; acc <= '0; eln <= '0; k <= '0; ln_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_vld) x <= data_in;
        S_PRE: begin
          if (special) ln_out <= spec_val;
          t   <= add_y;
          e_f <= e_f16;
          acc <= coef(4'(N_TERMS));
          k   <= 4'(N_TERMS - 1);
        end
        S_H_MUL, S_T_MUL: acc <= mul_y;
        S_H_ADD: begin acc <= add_y; k <= k - 4'd1; end
        S_E_MUL: eln <= mul_y;
        S_SUM:   ln_out <= add_y;
        default: ;
      endcase
    end
  end
endmodule
